lc3b_fetch_stage: RTL
=====================

Name: lc3b_fetch_stage

Overview:
IF stage of the LC-3b pipeline: owns the PC, issues word reads to instruction memory over a read/resp handshake, and presents the fetched instruction in an IF/ID register whose opcode field directly drives the decode control ROM. Absorbs decode-side stalls with a one-entry skid buffer. Handles PC redirects from downstream, including discarding an in-flight read.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
INSTR_BYTES, 2, PC increment per sequential fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_read  out  1  read request; held high with stable address until imem_resp
imem_address  out  16  byte address of the outstanding read (req_pc register)
imem_resp  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  16  instruction word
stall  in  1  decode cannot accept; IF/ID must hold
redirect  in  1  one-cycle pulse: fetch restarts at redirect_pc
redirect_pc  in  16  new fetch address (taken branch, JSR, TRAP target)
if_id_valid  out  1  IF/ID holds a live instruction
if_id_ir  out  16  instruction word
if_id_opcode  out  4  if_id_ir[15:12], typed lc3b_opcode
if_id_pc  out  16  address of the instruction
if_id_npc  out  16  if_id_pc + INSTR_BYTES

Behaviour:
- Reset: pc=RESET_PC, req_pc=0, state=IDLE, if_id_valid=0, if_id_ir/pc/npc=0, skid_valid=0, imem_read=0. Reset mid-read abandons the read; a resp arriving in the reset cycle is ignored.
- imem_read = (state != IDLE); imem_address = req_pc.
- States:
  - IDLE: redirect -> pc<=redirect_pc, stay IDLE. Else if !skid_valid -> launch (req_pc<=pc, pc<=pc+INSTR_BYTES, REQ).
  - REQ, no resp: redirect -> pc<=redirect_pc, DRAIN.
  - REQ, resp, no redirect -> word accepted (see routing). If skid will be empty after this edge, relaunch at pc (stay REQ, back-to-back); else IDLE.
  - REQ, resp with redirect -> word discarded, pc<=redirect_pc, IDLE.
  - DRAIN: resp -> discard, IDLE. Redirect -> pc<=redirect_pc, stay DRAIN.
- Routing of an accepted word {ir, pc=req_pc, npc=req_pc+INSTR_BYTES}:
  - !stall: IF/ID <= skid if skid_valid (accepted word -> skid); else IF/ID <= accepted word.
  - stall && if_id_valid: accepted word -> skid (never full here; no launch while skid_valid).
  - stall && !if_id_valid: word loads IF/ID directly.
- IF/ID with no new word: !stall -> IF/ID <= skid (clear skid_valid) or if_id_valid<=0; stall -> hold.
- Redirect has priority over stall and resp: clears if_id_valid and skid_valid the same edge.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000.
- Steady-state throughput: 1 instr/cycle with single-cycle resp and no stalls; the first fetch after reset or a redirect costs one IDLE cycle.
- Protocol assertions: imem_address stable while imem_read is high and resp is low; imem_resp never seen in IDLE.

Decomposition:
- lc3b_types: lc3b_word, lc3b_opcode (existing); add lc3b_if_id_t struct {valid, ir, pc, npc} and fetch state enum {IDLE, REQ, DRAIN}.
- Sub-module lc3b_skid_reg: one-entry valid/data holding register with load/clear. FSM and PC stay in the top.

Test Plan:
- Reset then 1-cycle-resp memory returning 16'h1234, 16'h5678 -> imem_address 0x0000, 0x0002 back-to-back; IF/ID pc 0x0000 then 0x0002, opcode 4'h1 then 4'h5.
- Stall high 3 cycles while resp arrives -> IF/ID holds, next word goes to skid, no launch while skid full; on release the skid word appears the next cycle with no loss or duplication.
- Redirect to 0x3000 while a read of 0x0004 is outstanding with 4-cycle latency -> DRAIN, discarded data never valid, next imem_address=0x3000.
- Redirect coincident with resp -> word discarded; if_id_valid=0 next cycle; fetch resumes at redirect_pc.
- pc=0xFFFE sequential fetch -> next imem_address 0x0000, if_id_npc=0x0000.
- rst asserted mid-REQ -> next cycle imem_read=0, if_id_valid=0; first fetch after release is RESET_PC.

Source files
------------

// File: rtl/lc3b_fetch_stage_pkg.sv
// Shared LC-3b fetch types: machine word, opcode field, IF/ID payload and fetch FSM states.
package lc3b_fetch_stage_pkg;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [3:0] {
      op_br   = 4'h0, op_add = 4'h1, op_ldb = 4'h2, op_stb = 4'h3,
      op_jsr  = 4'h4, op_and = 4'h5, op_ldr = 4'h6, op_str = 4'h7,
      op_rti  = 4'h8, op_not = 4'h9, op_ldi = 4'ha, op_sti = 4'hb,
      op_jmp  = 4'hc, op_shf = 4'hd, op_lea = 4'he, op_trap = 4'hf
   } lc3b_opcode;

   typedef struct packed {
      logic     valid;
      lc3b_word ir;
      lc3b_word pc;
      lc3b_word npc;
   } lc3b_if_id_t;

   typedef enum logic [1:0] {
      st_idle,
      st_req,
      st_drain
   } fetch_state_t;

endpackage

// File: rtl/lc3b_skid_reg.sv
// One-entry holding register for a fetched IF/ID payload.
// Latency: loaded word visible the cycle after load.
// Backpressure: none of its own; the owner never loads while it is full and not draining.
module lc3b_skid_reg
   import lc3b_fetch_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        clear,
   input  lc3b_if_id_t din,
   output lc3b_if_id_t dout
);

   always_ff @(posedge clk) begin
      if (rst) begin
         dout <= '0;
      end else if (clear) begin
         dout.valid <= 1'b0;
      end else if (load) begin
         dout <= din;
      end
   end

endmodule

// File: rtl/lc3b_fetch_stage.sv
// LC-3b IF stage: owns the PC, issues imem reads and fills the IF/ID register.
// Latency: one IDLE cycle before the first read, then one instruction per cycle with 1-cycle memory.
// Backpressure: stall holds IF/ID; one extra word parks in the skid and fetching pauses until it drains.
module lc3b_fetch_stage
   import lc3b_fetch_stage_pkg::*;
#(
   parameter lc3b_word RESET_PC    = 16'h0000,
   parameter int       INSTR_BYTES = 2
)
(
   input  logic        clk,
   input  logic        rst,
   output logic        imem_read,
   output logic [15:0] imem_address,
   input  logic        imem_resp,
   input  logic [15:0] imem_rdata,
   input  logic        stall,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        if_id_valid,
   output logic [15:0] if_id_ir,
   output lc3b_opcode  if_id_opcode,
   output logic [15:0] if_id_pc,
   output logic [15:0] if_id_npc
);

   localparam lc3b_word instr_step = lc3b_word'(INSTR_BYTES);

   fetch_state_t state;
   lc3b_word     pc;
   lc3b_word     req_pc;
   lc3b_if_id_t  if_id;
   lc3b_if_id_t  skid_q;
   lc3b_if_id_t  fetched;
   logic         accept;
   logic         skid_load;
   logic         skid_clear;
   logic         skid_valid_nxt;

   assign accept = (state == st_req) && imem_resp && !redirect;

   always_comb begin
      fetched.valid = 1'b1;
      fetched.ir    = imem_rdata;
      fetched.pc    = req_pc;
      fetched.npc   = req_pc + instr_step;
   end

   // The skid only fills while IF/ID is occupied: either stalled, or draining the older skid word.
   assign skid_load  = accept && (stall ? if_id.valid : skid_q.valid);
   assign skid_clear = redirect || (!stall && !accept);

   always_comb begin
      skid_valid_nxt = skid_q.valid;
      if (skid_clear)
         skid_valid_nxt = 1'b0;
      else if (skid_load)
         skid_valid_nxt = 1'b1;
   end

   lc3b_skid_reg u_skid (
      .clk   (clk),
      .rst   (rst),
      .load  (skid_load),
      .clear (skid_clear),
      .din   (fetched),
      .dout  (skid_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= st_idle;
         pc     <= RESET_PC;
         req_pc <= '0;
         if_id  <= '0;
      end else begin
         case (state)
            st_idle: begin
               if (redirect) begin
                  pc <= redirect_pc;
               end else if (!skid_q.valid) begin
                  req_pc <= pc;
                  pc     <= pc + instr_step;
                  state  <= st_req;
               end
            end
            st_req: begin
               if (redirect) begin
                  pc    <= redirect_pc;
                  state <= imem_resp ? st_idle : st_drain;
               end else if (imem_resp) begin
                  if (!skid_valid_nxt) begin
                     req_pc <= pc;
                     pc     <= pc + instr_step;
                  end else begin
                     state <= st_idle;
                  end
               end
            end
            st_drain: begin
               if (redirect)
                  pc <= redirect_pc;
               if (imem_resp)
                  state <= st_idle;
            end
            default: state <= st_idle;
         endcase

         if (redirect) begin
            if_id.valid <= 1'b0;
         end else if (accept) begin
            if (!stall)
               if_id <= skid_q.valid ? skid_q : fetched;
            else if (!if_id.valid)
               if_id <= fetched;
         end else if (!stall) begin
            if (skid_q.valid)
               if_id <= skid_q;
            else
               if_id.valid <= 1'b0;
         end
      end
   end

   assign imem_read    = (state != st_idle);
   assign imem_address = req_pc;
   assign if_id_valid  = if_id.valid;
   assign if_id_ir     = if_id.ir;
   assign if_id_opcode = lc3b_opcode'(if_id.ir[15:12]);
   assign if_id_pc     = if_id.pc;
   assign if_id_npc    = if_id.npc;

   a_addr_stable: assert property (@(posedge clk) disable iff (rst)
      (imem_read && !imem_resp) |=> $stable(imem_address));

   a_no_resp_idle: assert property (@(posedge clk) disable iff (rst)
      !(state == st_idle && imem_resp));

endmodule
